// File: rtl/time_keeper.sv
// time_keeper: BCD hh:mm:ss time-of-day counter with a one-second prescaler and two debounced set buttons.
// Defining TIME_KEEPER_AUTO_REPEAT_EN adds auto-repeat presses while a button is held.
module time_keeper #(
  parameter int TICKS_PER_SEC   = 31_500_000,
  parameter int DEBOUNCE_CYCLES = 315_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_hrs,
  input  logic       btn_min,
  output logic [3:0] sec_u,
  output logic [2:0] sec_d,
  output logic [3:0] min_u,
  output logic [2:0] min_d,
  output logic [3:0] hrs_u,
  output logic [1:0] hrs_d,
  output logic       sec_pulse
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [PW-1:0] pre_q, pre_d;
  logic          pend_q, pend_d, pulse_q, pulse_d;
  logic [3:0]    su_q, su_d, mu_q, mu_d, hu_q, hu_d;
  logic [2:0]    sd_q, sd_d, md_q, md_d;
  logic [1:0]    hd_q, hd_d;
  logic [1:0]    raw, press;
  logic          tick, te, apply, su9, sd5, mu9, md5, hr_last, inc_min, inc_hr;
  assign raw = {btn_min, btn_hrs};
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic s1_q, s2_q, deb_q, prev_q, done;
    logic [DW-1:0] cnt_q;
    // the counter only runs while the synchronised level disagrees with the accepted one
    assign done = s2_q != deb_q && cnt_q == DW'(DEBOUNCE_CYCLES - 1);
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        deb_q  <= 1'b0;
        prev_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        s1_q   <= raw[b];
        s2_q   <= s1_q;
        prev_q <= deb_q;
        deb_q  <= deb_q ^ done;
        cnt_q  <= (s2_q == deb_q || done) ? '0 : cnt_q + 1'b1;
      end
    end
`ifdef TIME_KEEPER_AUTO_REPEAT_EN
    localparam int HALF = TICKS_PER_SEC / 2;
    localparam int STEP = TICKS_PER_SEC >= 8 ? TICKS_PER_SEC / 8 : 1;
    localparam int RW   = $clog2(HALF + 1);
    logic [RW-1:0] rep_q;
    logic          rep;
    // after the first repeat, reload so the next one lands STEP cycles later
    assign rep = deb_q && rep_q == RW'(HALF);
    always_ff @(posedge clk)
      rep_q <= (reset || !deb_q) ? '0 : rep ? RW'(HALF - STEP + 1) : rep_q + 1'b1;
    assign press[b] = (deb_q & ~prev_q) | rep;
`else
    assign press[b] = deb_q & ~prev_q;
`endif
  end
  assign tick    = pre_q == PW'(TICKS_PER_SEC - 1);
  assign te      = tick | pend_q;
  assign apply   = te & ~|press;
  assign su9     = su_q == 4'd9;
  assign sd5     = sd_q == 3'd5;
  assign mu9     = mu_q == 4'd9;
  assign md5     = md_q == 3'd5;
  assign hr_last = hd_q == 2'd2 && hu_q == 4'd3;
  // a minutes press never carries into hours; only the tick cascade does
  assign inc_min = press[1] | (apply & su9 & sd5);
  assign inc_hr  = press[0] | (apply & su9 & sd5 & mu9 & md5);
  always_comb begin
    su_d    = press[1] ? 4'd0 : apply ? (su9 ? 4'd0 : su_q + 4'd1) : su_q;
    sd_d    = press[1] ? 3'd0 : (apply & su9) ? (sd5 ? 3'd0 : sd_q + 3'd1) : sd_q;
    mu_d    = inc_min ? (mu9 ? 4'd0 : mu_q + 4'd1) : mu_q;
    md_d    = (inc_min & mu9) ? (md5 ? 3'd0 : md_q + 3'd1) : md_q;
    hu_d    = inc_hr ? ((hr_last | hu_q == 4'd9) ? 4'd0 : hu_q + 4'd1) : hu_q;
    hd_d    = inc_hr ? (hr_last ? 2'd0 : hu_q == 4'd9 ? hd_q + 2'd1 : hd_q) : hd_q;
    pre_d   = (press[1] | tick) ? '0 : pre_q + 1'b1;
    pend_d  = ~press[1] & |press & te;
    pulse_d = apply;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      su_q    <= '0;
      sd_q    <= '0;
      mu_q    <= '0;
      md_q    <= '0;
      hu_q    <= '0;
      hd_q    <= '0;
      pre_q   <= '0;
      pend_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      su_q    <= su_d;
      sd_q    <= sd_d;
      mu_q    <= mu_d;
      md_q    <= md_d;
      hu_q    <= hu_d;
      hd_q    <= hd_d;
      pre_q   <= pre_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
    end
  end
  assign sec_u     = su_q;
  assign sec_d     = sd_q;
  assign min_u     = mu_q;
  assign min_d     = md_q;
  assign hrs_u     = hu_q;
  assign hrs_d     = hd_q;
  assign sec_pulse = pulse_q;
endmodule

// File: doc/time_keeper.md
# time_keeper

Time-of-day source for the VGA clock display: a BCD hours/minutes/seconds counter driven by a one-second prescaler on the pixel clock. It has two debounced push-button set inputs. Its six digit outputs feed the display stage directly, and every output value is a valid BCD digit on every cycle: no transient 10, 6 or 24 states.

## Interface
- `TICKS_PER_SEC`, default 31_500_000: clk cycles per second. Must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 315_000: cycles a synchronised button level must hold before it is accepted (10 ms at 31.5 MHz). Must be ≥ 1.
- `clk`, in, 1: pixel clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `btn_hrs`, in, 1: raw asynchronous push-button, active-high; sets hours.
- `btn_min`, in, 1: raw asynchronous push-button, active-high; sets minutes.
- `sec_u`, out, 4: seconds units, 0–9.
- `sec_d`, out, 3: seconds tens, 0–5.
- `min_u`, out, 4: minutes units, 0–9.
- `min_d`, out, 3: minutes tens, 0–5.
- `hrs_u`, out, 4: hours units, 0–9 (0–3 when `hrs_d` = 2).
- `hrs_d`, out, 2: hours tens, 0–2.
- `sec_pulse`, out, 1: one-cycle strobe, high in the cycle the seconds digits change because of a tick.

## Operation
- **Reset:**
  - All digits 0 (00:00:00); `sec_pulse` = 0.
  - Prescaler, debounce counters, synchronisers, debounced states and tick-pending all cleared.
  - Reset mid-count discards all partial state.
- **Prescaler:**
  - Counts 0..`TICKS_PER_SEC`-1 and wraps.
  - Raises internal `tick` in the wrap cycle.
- **Tick cascade:** applied in a single cycle.
  - `sec_u` 9→0 carries into `sec_d`; `sec_d` 5→0 carries into `min_u`.
  - `min_u` 9→0 carries into `min_d`; `min_d` 5→0 carries into `hrs_u`.
  - `hrs_u` 9→0 carries into `hrs_d`.
  - 23:59:59 → 00:00:00.
- **Button path** (per button):
  - 2-FF synchroniser.
  - Debounce counter: counts while the synchronised level differs from the debounced state; clears to 0 whenever they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 while still differing, the debounced state flips on the next edge and the counter clears.
  - A rising edge of the debounced state produces one `press` strobe.
- **btn_min press:**
  - Minutes +1 with wrap 59→00; no carry into hours.
  - Seconds digits and prescaler cleared to 0.
- **btn_hrs press:** hours +1 with wrap 23→00; minutes and seconds untouched.
- **Simultaneous events:**
  - Both presses in the same cycle: both applied; seconds and prescaler cleared because of `btn_min`.
  - Press coincident with `tick`: the press is applied and `tick` is latched into tick-pending, then applied the next cycle with `sec_pulse` in that cycle.
  - Exception: a `btn_min` press clears the prescaler and drops the pending tick.
  - A new press arriving while a tick is pending: the press is applied and the pending tick is held another cycle.

## Timing
- All outputs are registered.
- Digits update on the clock edge that ends the tick cycle.
- `sec_pulse` is high for the cycle after that edge, aligned with the new digit values.
- Seconds period is exactly `TICKS_PER_SEC` cycles, except when changed by a `btn_min` clear.
- **Button latency:**
  - Raw input stable high from cycle 0.
  - Synchronised output high at cycle 2.
  - Debounced state high at cycle 2+`DEBOUNCE_CYCLES`.
  - Digit change visible at cycle 3+`DEBOUNCE_CYCLES`.
- Release is debounced identically but produces no action.
- Any glitch shorter than `DEBOUNCE_CYCLES` restarts the count.
- Maximum of one increment per debounced press (without `AUTO_REPEAT_EN`).

## Configuration
- **`TIME_KEEPER_AUTO_REPEAT_EN` defined:**
  - While a debounced button stays high, after `TICKS_PER_SEC`/2 cycles it generates an additional `press` strobe.
  - Further strobes follow every `TICKS_PER_SEC`/8 cycles until release.
  - The repeat counter is per button, cleared on release and on reset.
  - Repeat strobes obey the same simultaneity rules as normal presses.
- **Not defined:** no repeat logic is synthesised; holding a button gives exactly one increment.

## Test plan
All scenarios use `TICKS_PER_SEC`=10, `DEBOUNCE_CYCLES`=4.
- **Reset and first tick:** hold `reset` 3 cycles, release → digits 00:00:00. First `sec_pulse` comes 10 cycles later with `sec_u`=1; pulses are spaced exactly 10 cycles apart.
- **Full wrap:** run 86_400 ticks → every cycle in-range BCD; 09:59:59→10:00:00 and 19:59:59→20:00:00 on single ticks; 23:59:59→00:00:00.
- **Debounce:** raw `btn_min` pulses of 1, 2 and 3 cycles → no change. A 10-cycle hold at 00:58:07 → 00:59:00 at cycle 7; a second hold → 00:00:00 with `hrs` still 0.
- **Hours set:** `btn_hrs` at 23:10:20 → 00:10:20.
- **Collision:** align a `btn_hrs` press with the 09:59:59 tick → hours 10 first, then 11:00:00 the next cycle with `sec_pulse`. Align `btn_min` with a tick → no `sec_pulse` and seconds 00.
- **Auto-repeat** (with macro): hold `btn_hrs` 40 cycles → increments at cycles 7, 12, 13, 14, … per the repeat schedule. Without the macro → a single increment.
